// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the architectural HI/LO pair.
// A multi-cycle op computes its full result at the accepting edge into
// pending registers, then holds busy for a fixed count before committing,
// so the timing seen by the hazard unit is fixed and independent of the
// operand values.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  // Architectural and pending state.
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_pend_hi, r_pend_lo;
  logic        r_pend_dz;
  logic [3:0]  r_cnt;

  // Datapath for the op presented this cycle.
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_dvsr_s, w_dvsr_u;
  logic [31:0] w_uq_s, w_ur_s, w_q_s, w_r_s;
  logic [31:0] w_q_u, w_r_u;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_b_zero;

  // Products: a 64-bit modular multiply of sign- or zero-extended operands
  // yields the exact signed or unsigned 64-bit product.
  always_comb begin
    w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    w_prod_u = {32'b0, A} * {32'b0, B};
  end

  // Division via magnitudes so truncation toward zero and the remainder
  // sign (that of the dividend) are explicit; 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0. A zero divisor is replaced by 1 so the
  // datapath stays defined; that result is never committed.
  always_comb begin
    w_b_zero = (B == 32'd0);
    w_abs_a  = A[31] ? (~A + 32'd1) : A;
    w_abs_b  = B[31] ? (~B + 32'd1) : B;
    w_dvsr_s = w_b_zero ? 32'd1 : w_abs_b;
    w_dvsr_u = w_b_zero ? 32'd1 : B;
    w_uq_s   = w_abs_a / w_dvsr_s;
    w_ur_s   = w_abs_a % w_dvsr_s;
    w_q_s    = (A[31] ^ B[31]) ? (~w_uq_s + 32'd1) : w_uq_s;
    w_r_s    = A[31] ? (~w_ur_s + 32'd1) : w_ur_s;
    w_q_u    = A / w_dvsr_u;
    w_r_u    = A % w_dvsr_u;
  end

  // Select the result that would be parked in the pending registers.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (md_op)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV:   begin w_res_hi = w_r_s;           w_res_lo = w_q_s;          end
      OP_DIVU:  begin w_res_hi = w_r_u;           w_res_lo = w_q_u;          end
      default:  ;
    endcase
  end

  // Count down while busy and commit on the 1->0 step; accept new ops only
  // when idle. Reset drops everything, including any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_dz <= 1'b0;
      r_cnt     <= 4'd0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1 && !r_pend_dz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          r_pend_hi <= w_res_hi;
          r_pend_lo <= w_res_lo;
          r_pend_dz <= 1'b0;
          r_cnt     <= LP_MULT_CNT;
        end
        OP_DIV, OP_DIVU: begin
          r_pend_hi <= w_res_hi;
          r_pend_lo <= w_res_lo;
          r_pend_dz <= w_b_zero;
          r_cnt     <= LP_DIV_CNT;
        end
        OP_MTHI: r_hi <= A;
        OP_MTLO: r_lo <= A;
        default: ;
      endcase
    end
  end

  assign busy = (r_cnt != 4'd0);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit. Expected HI/LO for each
// multi-cycle op are queued at issue and popped when busy drops.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;  // committed architectural model

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; drives a start for one cycle.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = 32'd0; B = 32'd0;
  endtask

  // Waits out busy, checking hold-off of HI/LO, then pops and compares.
  task automatic finish_op(input string tag, input int cycles);
    int n;
    logic [63:0] e;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (hi !== m_hi || lo !== m_lo) begin
        check({tag, "_hold_hi"}, hi, m_hi);
        check({tag, "_hold_lo"}, lo, m_lo);
      end
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(cycles));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      m_hi = e[63:32]; m_lo = e[31:0];
      check({tag, "_hi"}, hi, m_hi);
      check({tag, "_lo"}, lo, m_lo);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] ehi, input logic [31:0] elo);
    sb_q.push_back({ehi, elo});
    drive(op, a, b);
    finish_op(tag, cycles);
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    drive(op, a, 32'd0);
    if (op == 3'd4) m_hi = a; else m_lo = a;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_hi", hi, 32'd0);
    check("rel_lo", lo, 32'd0);

    // Multiply.
    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

    // Divide, issued back-to-back in the first idle cycle.
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("divovf",3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // Divide by zero leaves preloaded HI/LO untouched.
    mt("mthi", 3'd4, 32'h11);
    mt("mtlo", 3'd5, 32'h22);
    run_op("divz",  3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_op("divuz", 3'd3, 32'd9, 32'd0, 10, 32'h11, 32'h22);

    // Start while busy is ignored; MTLO in first idle cycle is accepted.
    sb_q.push_back({32'd0, 32'd6});
    drive(3'd0, 32'd2, 32'd3);
    check("sb_busy_after_e0", 32'(busy), 32'd1);
    drive(3'd4, 32'hABCD, 32'd0);
    drive(3'd2, 32'd7, 32'd2);
    drive(3'd5, 32'h9999, 32'd0);
    check("sb_hi_hold", hi, m_hi);
    check("sb_lo_hold", lo, m_lo);
    finish_op("busyign", 2);  // two busy cycles remain after the three ignored starts
    mt("mtlo_b2b", 3'd5, 32'h55);

    // Reset mid-operation: asynchronous clear, no later commit.
    start = 1'b1; md_op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);          // third busy cycle
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;            // start sampled at the first edge after release
    m_hi = 32'd0; m_lo = 32'd0;
    mt("post_rst_mthi", 3'd4, 32'h77);
    repeat (10) @(negedge clk);
    check("norecommit_busy", 32'(busy), 32'd0);
    check("norecommit_hi", hi, 32'h77);
    check("norecommit_lo", lo, 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It consumes the operands and decoded op that the ID/EX pipeline register delivers (A2, B2 and the decoded Instr2 opcode) and owns the architectural HI/LO registers. It runs multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO. Its `busy` output drives the hazard unit, which stalls IF/ID and bubbles ID/EX while any MD-class instruction (including MFHI/MFLO) waits in ID.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU; legal range 1..15
- DIV_CYCLES, 10, busy duration for DIV/DIVU; legal range 1..15

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  EX-stage instruction is an MD op; qualifies md_op, A, B for one cycle
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored
- A  input  32  rs operand (forwarded A2)
- B  input  32  rt operand (forwarded B2)
- busy  output  1  multi-cycle operation in progress
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- State:
  - HI, LO: 32-bit each.
  - Pending result registers: 32-bit each.
  - Down-counter cnt: 4 bits.
  - busy = (cnt != 0); busy is registered-state derived and has no combinational path from start.
- IDLE (cnt = 0), start = 1 at a rising edge:
  - md_op 0–3: compute the result from A and B at that edge and store it in the pending registers. Load cnt with MULT_CYCLES (ops 0–1) or DIV_CYCLES (ops 2–3).
  - md_op 4: HI <= A. md_op 5: LO <= A. cnt stays 0.
  - md_op 6–7: no effect.
- BUSY (cnt != 0):
  - cnt decrements by 1 each edge.
  - On the edge where cnt goes from 1 to 0, commit the pending values: HI <= pending high word, LO <= pending low word.
  - start is ignored for every md_op, including MTHI/MTLO. The hazard unit guarantees start does not occur here; the bench must still check that it is ignored.
- Arithmetic:
  - MULT: signed 32×32 -> 64; HI = product[63:32], LO = product[31:0].
  - MULTU: same, with unsigned operands.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend (A).
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
- Divide by zero (B = 0, DIV or DIVU):
  - The unit stays busy for DIV_CYCLES.
  - HI and LO keep their pre-start values; the commit is suppressed.
- Reset (reset = 0, at any time, asynchronous):
  - HI = 0, LO = 0, cnt = 0, pending registers = 0, so busy = 0 immediately.
  - Any in-flight operation is discarded without commit.
- Outputs hi and lo reflect the architectural registers. The pending value is never visible before commit.

## Timing
- start sampled at edge E0 (MULT):
  - busy = 1 from just after E0 until edge E0+MULT_CYCLES.
  - New HI/LO are visible, with busy = 0, from just after E0+MULT_CYCLES.
  - DIV behaves the same with DIV_CYCLES.
- MTHI/MTLO sampled at E0: new value visible just after E0; busy stays 0.
- Back-to-back: start may be asserted in the first cycle where busy = 0 after a commit. That start is accepted, and it sees the committed HI/LO.
- Reset values: busy = 0, hi = 0x00000000, lo = 0x00000000.
- Reset deassertion takes effect at the next edge; start sampled at that edge is honoured.

## Test plan
- Reset sequence: hold reset = 0 for 3 cycles -> busy = 0, hi = 0, lo = 0. Release reset -> all three remain 0.
- MULT and MULTU, A = 0xFFFFFFFE, B = 3:
  - MULT -> busy high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - MULTU -> HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV and DIVU:
  - DIV A = 0xFFFFFFF9 (−7), B = 2 -> busy for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU A = 7, B = 2 -> LO = 3, HI = 1.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Divide by zero: preload HI = 0x11, LO = 0x22 via MTHI/MTLO, then DIV A = 5, B = 0 -> busy for 10 cycles, then HI = 0x11, LO = 0x22.
- Start while busy: during MULT 2×3, assert start with MTHI A = 0xABCD and with DIV -> both ignored. Final HI = 0, LO = 6; busy deasserts on schedule (5 cycles). An immediate follow-up MTLO 0x55 in the first idle cycle -> lo = 0x55 on the next cycle.
- Reset mid-operation: start MULTU 0xFFFFFFFF × 0xFFFFFFFF, pull reset low in the 3rd busy cycle -> busy, hi and lo go to 0 without waiting for a clock edge. No commit occurs after reset is released.
